// File: rtl/rf_sched_pkg.sv
// Shared types for the register-file write-port scheduler: register/data widths
// and the buffered writeback entry.
package rf_sched_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  function automatic logic is_r0(input logic [AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO of pending writeback entries, with an occupancy counter and a
// parallel destination-address match across every valid entry.
module wb_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [AW-1:0]            match_addr_i,
  output logic                     match_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PW:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   idx;

  // Pointers carry a wrap bit so equal indices distinguish full from empty.
  assign empty_o = (rd_ptr_q == wr_ptr_q);
  assign full_o  = (rd_ptr_q[PW] != wr_ptr_q[PW]) &&
                   (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_entry_i;
  end

  always_comb begin
    match_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q[PW-1:0] + PW'(k);
      if ((CW'(k) < count_q) && (mem_q[idx].addr == match_addr_i)) match_o = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-unit results, forcing a drain when the buffer has waited too long.
module rf_wb_arbiter
  import rf_sched_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pipe_wb_valid,
  input  logic [AW-1:0]          pipe_wb_addr,
  input  logic [DW-1:0]          pipe_wb_data,
  output logic                   pipe_stall,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [AW-1:0]          lu_addr,
  input  logic [DW-1:0]          lu_data,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  input  logic [AW-1:0]          chk_addr,
  output logic                   chk_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  wb_entry_t     head, lu_entry;
  logic          empty, full, push, pop, match;
  logic          pipe_req, stall_raw, pipe_grant;

  assign pipe_req  = pipe_wb_valid && !is_r0(pipe_wb_addr);
  assign stall_raw = (starve_q == LIMIT) && !empty;
  // No pass-through: a pop in the same cycle never frees a slot for the push.
  assign lu_ready  = reset_n && !full;
  assign push      = lu_valid && lu_ready && !is_r0(lu_addr);
  assign lu_entry  = '{addr: lu_addr, data: lu_data};

  assign pipe_stall  = reset_n && stall_raw;
  assign chk_pending = reset_n && !is_r0(chk_addr) && match;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_ni       (reset_n),
    .push_i       (push),
    .push_entry_i (lu_entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (fifo_count),
    .match_addr_i (chk_addr),
    .match_o      (match)
  );

  always_comb begin
    pop        = 1'b0;
    pipe_grant = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = head.addr;
    rf_wdata   = head.data;
    if (reset_n) begin
      if (stall_raw) begin
        pop   = 1'b1;
        rf_we = 1'b1;
      end else if (pipe_req) begin
        pipe_grant = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = pipe_wb_addr;
        rf_wdata   = pipe_wb_data;
      end else if (!empty) begin
        pop   = 1'b1;
        rf_we = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || empty)                         starve_d = '0;
    else if (pipe_grant && starve_q != LIMIT) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

endmodule
